// File: rtl/soc_system_ops_scanner_if.sv
// Shared PIO read path between the ops scanner (master) and the externally muxed PIO slaves.
interface soc_system_ops_scanner_if #(
    parameter int SEL_W  = 4,
    parameter int DATA_W = 32
);
    logic [SEL_W-1:0]  m_sel;
    logic [1:0]        m_address;
    logic [DATA_W-1:0] m_readdata;

    modport master (output m_sel, output m_address, input m_readdata);
    modport slave  (input m_sel, input m_address, output m_readdata);
endinterface

// File: rtl/soc_system_ops_scanner.sv
// Scans NUM_PORTS PIO input slaves into a shadow bank, then commits it atomically into a
// snapshot bank that software reads coherently. Scans start on a pulse or on a periodic tick.
module soc_system_ops_scanner #(
    parameter int NUM_PORTS = 13,
    parameter int SEL_W     = 4,
    parameter int DATA_W    = 32,
    parameter int PERIOD    = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     start,
    soc_system_ops_scanner_if.master bus,
    input  logic [SEL_W-1:0]         snap_idx,
    output logic [DATA_W-1:0]        snap_data,
    output logic                     busy,
    output logic                     scan_done,
    output logic                     overrun,
    output logic [15:0]              scan_count
);
    localparam int                 TMR_W      = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [TMR_W-1:0]   TMR_RELOAD = TMR_W'(PERIOD - 1);
    localparam logic [SEL_W-1:0]   LAST_IDX   = SEL_W'(NUM_PORTS - 1);
    localparam logic [SEL_W:0]     NUM_ENT    = (SEL_W + 1)'(NUM_PORTS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    state_t             state_r;
    logic [SEL_W-1:0]   idx_r;
    logic [SEL_W-1:0]   m_sel_r;
    logic               busy_r;
    logic               scan_done_r;
    logic               overrun_r;
    logic [15:0]        scan_count_r;
    logic [TMR_W-1:0]   timer_r;
    logic               tick_s;
    logic               snap_hit_s;
    logic [DATA_W-1:0]  snap_data_r;
    logic [DATA_W-1:0]  shadow_r [NUM_PORTS];
    logic [DATA_W-1:0]  snap_r   [NUM_PORTS];

    assign bus.m_sel     = m_sel_r;
    assign bus.m_address = 2'b00;
    assign snap_data     = snap_data_r;
    assign busy          = busy_r;
    assign scan_done     = scan_done_r;
    assign overrun       = overrun_r;
    assign scan_count    = scan_count_r;

    // Periodic tick request and snapshot index range decode.
    always_comb begin
        tick_s     = 1'b0;
        snap_hit_s = 1'b0;
        if (enable && (timer_r == {TMR_W{1'b0}})) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if ({1'b0, snap_idx} < NUM_ENT) begin
            snap_hit_s = 1'b1;
        end else begin
            snap_hit_s = 1'b0;
        end
    end

    // Free-running period timer; runs whether or not periodic scanning is enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r <= TMR_RELOAD;
        end else if (timer_r == {TMR_W{1'b0}}) begin
            timer_r <= TMR_RELOAD;
        end else begin
            timer_r <= timer_r - {{(TMR_W-1){1'b0}}, 1'b1};
        end
    end

    // Scan sequencer with registered select, status and counter outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= {SEL_W{1'b0}};
            m_sel_r      <= {SEL_W{1'b0}};
            busy_r       <= 1'b0;
            scan_done_r  <= 1'b0;
            overrun_r    <= 1'b0;
            scan_count_r <= 16'h0000;
        end else begin
            scan_done_r <= 1'b0;
            // A tick that finds the sequencer busy is dropped, never queued.
            overrun_r   <= tick_s && (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (start || tick_s) begin
                        state_r <= ST_ISSUE;
                        idx_r   <= {SEL_W{1'b0}};
                        m_sel_r <= {SEL_W{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        m_sel_r <= {SEL_W{1'b0}};
                        busy_r  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        state_r <= ST_ISSUE;
                        idx_r   <= idx_r + {{(SEL_W-1){1'b0}}, 1'b1};
                        m_sel_r <= idx_r + {{(SEL_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_COMMIT: begin
                    state_r      <= ST_IDLE;
                    m_sel_r      <= {SEL_W{1'b0}};
                    busy_r       <= 1'b0;
                    scan_done_r  <= 1'b1;
                    scan_count_r <= scan_count_r + 16'h0001;
                end
                default: begin
                    state_r <= ST_IDLE;
                    m_sel_r <= {SEL_W{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Shadow capture per port, atomic snapshot commit, and registered snapshot read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                shadow_r[i] <= {DATA_W{1'b0}};
                snap_r[i]   <= {DATA_W{1'b0}};
            end
            snap_data_r <= {DATA_W{1'b0}};
        end else begin
            if (state_r == ST_CAPTURE) begin
                shadow_r[idx_r] <= bus.m_readdata;
            end else begin
                shadow_r <= shadow_r;
            end
            if (state_r == ST_COMMIT) begin
                snap_r <= shadow_r;
            end else begin
                snap_r <= snap_r;
            end
            // Reads in the commit cycle see the old bank: snap_r updates on this same edge.
            if (snap_hit_s) begin
                snap_data_r <= snap_r[snap_idx];
            end else begin
                snap_data_r <= {DATA_W{1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_soc_system_ops_scanner.sv
// Scoreboard bench for soc_system_ops_scanner: directed stimulus pushes expected responses,
// a negedge monitor pops them whenever the DUT presents scan_done, overrun or read data.
module tb_soc_system_ops_scanner;
    localparam int NP  = 13;
    localparam int SW  = 4;
    localparam int DW  = 32;
    localparam int PER = 64;

    typedef struct {
        logic [15:0] cnt;
        int          cyc;
    } done_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           enable;
    logic           start;
    logic [SW-1:0]  snap_idx;
    logic [DW-1:0]  snap_data;
    logic           busy;
    logic           scan_done;
    logic           overrun;
    logic [15:0]    scan_count;

    logic [DW-1:0]  in_port [16];
    int             cyc;
    int             vectors = 0;
    int             miscompares = 0;
    done_t          done_q[$];
    int             ovr_q[$];
    logic [DW-1:0]  rd_q[$];
    logic           rd_req = 1'b0;
    logic           rd_req_d = 1'b0;
    done_t          mon_d;

    soc_system_ops_scanner_if #(.SEL_W(SW), .DATA_W(DW)) bus ();

    soc_system_ops_scanner #(.NUM_PORTS(NP), .SEL_W(SW), .DATA_W(DW), .PERIOD(PER)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .start      (start),
        .bus        (bus.master),
        .snap_idx   (snap_idx),
        .snap_data  (snap_data),
        .busy       (busy),
        .scan_done  (scan_done),
        .overrun    (overrun),
        .scan_count (scan_count)
    );

    always #5 clk = ~clk;

    // PIO slaves: registered readdata, one cycle after the select.
    always_ff @(posedge clk) bus.m_readdata <= in_port[bus.m_sel];

    // Cycle counter restarts at every reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always_ff @(posedge clk) rd_req_d <= rd_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        if (cyc > n) chk("schedule", cyc, n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse_start(input bit expect_scan, input logic [15:0] cnt);
        start = 1'b1;
        // Start is sampled on the next edge; the commit is visible 27 edges after that.
        if (expect_scan) done_q.push_back('{cnt, cyc + 28});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rd(input int idx, input logic [DW-1:0] exp);
        snap_idx = SW'(idx);
        rd_req   = 1'b1;
        rd_q.push_back(exp);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Monitor: compare every DUT-presented event with the head of its queue.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (rd_req_d) begin
                if (rd_q.size() == 0) chk("snap_data unexpected", 32'd1, 32'd0);
                else                  chk("snap_data", snap_data, rd_q.pop_front());
            end
            if (scan_done) begin
                if (done_q.size() == 0) begin
                    chk("scan_done unexpected", 32'd1, 32'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("scan_count", {16'h0000, scan_count}, {16'h0000, mon_d.cnt});
                    chk("scan_done cycle", cyc, mon_d.cyc);
                end
            end
            if (overrun) begin
                if (ovr_q.size() == 0) chk("overrun unexpected", 32'd1, 32'd0);
                else                   chk("overrun cycle", cyc, ovr_q.pop_front());
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        start    = 1'b0;
        snap_idx = '0;
        for (int k = 0; k < 16; k++) in_port[k] = 32'h1000 + k;
        repeat (3) @(negedge clk);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst m_sel", {28'd0, bus.m_sel}, 32'd0);
        chk("rst m_address", {30'd0, bus.m_address}, 32'd0);
        chk("rst scan_count", {16'd0, scan_count}, 32'd0);
        chk("rst snap_data", snap_data, 32'd0);
        reset_n = 1'b1;

        // 1) basic scan: select walks 0..12, two cycles per port
        wait_cyc(2);
        pulse_start(1'b1, 16'd1);
        for (int n = 3; n <= 28; n++) begin
            wait_cyc(n);
            chk("m_sel step", {28'd0, bus.m_sel}, (n - 3) / 2);
            chk("busy in scan", {31'd0, busy}, 32'd1);
        end
        wait_cyc(30);
        chk("busy after scan", {31'd0, busy}, 32'd0);
        chk("m_sel idle", {28'd0, bus.m_sel}, 32'd0);
        wait_cyc(31);
        for (int k = 0; k < 16; k++) rd(k, (k < NP) ? 32'h1000 + k : 32'd0);

        // 2) coherency: inputs change mid-scan, reads stay old up to the commit cycle
        wait_cyc(50);
        for (int k = 0; k < 16; k++) in_port[k] = 32'h3000 + k;
        wait_cyc(55);
        pulse_start(1'b1, 16'd2);
        wait_cyc(67);
        for (int k = 0; k < 16; k++) in_port[k] = 32'h2000 + k;
        wait_cyc(70);
        for (int k = 0; k < NP; k++) rd(k, 32'h1000 + k);
        for (int k = 0; k < 16; k++) rd(k, (k >= NP) ? 32'd0 : (k <= 5) ? 32'h3000 + k : 32'h2000 + k);

        // 4) start while busy is ignored
        wait_cyc(105);
        pulse_start(1'b1, 16'd3);
        wait_cyc(115);
        pulse_start(1'b0, 16'd0);

        // 3) periodic scans; start coinciding with a tick gives one scan; overrun when busy
        wait_cyc(140);
        enable = 1'b1;
        wait_cyc(191);
        pulse_start(1'b1, 16'd4);
        wait_cyc(200);
        done_q.push_back('{16'd5, 283});
        wait_cyc(300);
        pulse_start(1'b1, 16'd6);
        ovr_q.push_back(320);
        done_q.push_back('{16'd7, 411});
        wait_cyc(390);
        enable = 1'b0;

        // 5) reset during CAPTURE of port 5
        wait_cyc(440);
        snap_idx = 4'd3;
        wait_cyc(460);
        pulse_start(1'b0, 16'd0);
        wait_cyc(472);
        chk("m_sel before reset", {28'd0, bus.m_sel}, 32'd5);
        reset_n = 1'b0;
        #1;
        chk("mid rst busy", {31'd0, busy}, 32'd0);
        chk("mid rst m_sel", {28'd0, bus.m_sel}, 32'd0);
        chk("mid rst scan_count", {16'd0, scan_count}, 32'd0);
        chk("mid rst snap_data", snap_data, 32'd0);
        chk("mid rst scan_done", {31'd0, scan_done}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(2);
        for (int k = 0; k < 16; k++) rd(k, 32'd0);
        wait_cyc(19);
        for (int k = 0; k < 16; k++) in_port[k] = 32'h5000 + k;
        wait_cyc(20);
        pulse_start(1'b1, 16'd1);
        wait_cyc(50);
        for (int k = 0; k < 16; k++) rd(k, (k < NP) ? 32'h5000 + k : 32'd0);

        // 6) scan_count wrap
        wait_cyc(70);
        force dut.scan_count_r = 16'hFFFE;
        #1;
        release dut.scan_count_r;
        wait_cyc(71);
        chk("scan_count preset", {16'd0, scan_count}, 32'h0000FFFE);
        wait_cyc(72);
        pulse_start(1'b1, 16'hFFFF);
        wait_cyc(110);
        pulse_start(1'b1, 16'h0000);
        wait_cyc(150);

        chk("pending scan_done", done_q.size(), 32'd0);
        chk("pending overrun", ovr_q.size(), 32'd0);
        chk("pending reads", rd_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
